// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch NOP encoding and the
// instruction-memory DMA load states.
package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } imem_dma_state_e;

endpackage

// File: rtl/imem_sram_1r1w.sv
// Instruction SRAM: one synchronous read port, one synchronous write port.
// Ports: clk, re/raddr/rdata (1-cycle read, rdata holds when re=0),
//        we/waddr/wdata (write on clock edge). The array has no reset.
module imem_sram_1r1w #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder with DMA fill port.
// Ports: clk_i/rst_i; fetch side pc_i, fetch_en_i, flush_i -> instr_o, pc_o,
//        instr_valid_o, fetch_err_o (1-cycle latency); DMA side dma_req_i,
//        dma_addr_i, dma_wdata_i, dma_last_i -> dma_ack_o, dma_stall_o.
module imem_fetch_responder
    import riscv_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 1024,
    parameter logic [XLEN-1:0]  BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            fetch_en_i,
    input  logic            flush_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_valid_o,
    output logic            fetch_err_o,
    input  logic            dma_req_i,
    input  logic [XLEN-1:0] dma_addr_i,
    input  logic [31:0]     dma_wdata_i,
    input  logic            dma_last_i,
    output logic            dma_ack_o,
    output logic            dma_stall_o
);

    localparam int              AW   = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * 4);

    imem_dma_state_e state;

    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            err_q;
    logic            nop_q;

    logic [XLEN-1:0] f_off;
    logic            f_fault;
    logic            f_go;
    logic [XLEN-1:0] d_off;
    logic            d_hit;
    logic            d_we;
    logic [31:0]     rdata;

    // Offsets wrap mod 2^XLEN, so addresses below BASE_ADDR land
    // far above SPAN and are caught by the range compare.
    assign f_off   = pc_i - BASE_ADDR;
    assign f_fault = (f_off >= SPAN) || (pc_i[1:0] != 2'b00);
    assign d_off   = dma_addr_i - BASE_ADDR;
    assign d_hit   = (d_off < SPAN);

    assign dma_stall_o = (state != IDLE);
    assign dma_ack_o   = (state == LOAD) && dma_req_i;
    assign d_we        = dma_ack_o && d_hit;

    // A fetch launched on the same edge as the first DMA request still
    // completes: the stall only rises once the FSM has left IDLE.
    assign f_go = fetch_en_i && !dma_stall_o && !flush_i;

    imem_sram_1r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk_i),
        .re    (f_go && !f_fault),
        .raddr (f_off[AW+1:2]),
        .rdata (rdata),
        .we    (d_we),
        .waddr (d_off[AW+1:2]),
        .wdata (dma_wdata_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pc_q    <= BASE_ADDR;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            nop_q   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dma_req_i) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (dma_req_i && dma_last_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (flush_i) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                nop_q   <= 1'b1;
            end else if (f_go) begin
                pc_q    <= pc_i;
                valid_q <= 1'b1;
                err_q   <= f_fault;
                nop_q   <= f_fault;
            end
        end
    end

    // The SRAM output holds when no read is issued, so the mux keeps
    // the previous instruction during idle or stalled cycles.
    assign instr_o       = nop_q ? NOP_INSTR : rdata;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
    assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed testbench for imem_fetch_responder.
// Drives fetch and DMA vectors and compares against hand-computed values.
module tb_imem_fetch_responder;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid;
    logic        err;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_last;
    logic        dma_ack;
    logic        dma_stall;

    int checks;
    int failures;
    int acks;

    imem_fetch_responder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_i          (pc),
        .fetch_en_i    (fetch_en),
        .flush_i       (flush),
        .instr_o       (instr),
        .pc_o          (pc_out),
        .instr_valid_o (valid),
        .fetch_err_o   (err),
        .dma_req_i     (dma_req),
        .dma_addr_i    (dma_addr),
        .dma_wdata_i   (dma_wdata),
        .dma_last_i    (dma_last),
        .dma_ack_o     (dma_ack),
        .dma_stall_o   (dma_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until acked (bounded).
    task automatic dma_beat(input logic [31:0] a, input logic [31:0] d,
                            input logic l);
        logic got;
        logic done;
        done      = 1'b0;
        dma_req   = 1'b1;
        dma_addr  = a;
        dma_wdata = d;
        dma_last  = l;
        for (int i = 0; i < 8; i++) begin
            got = dma_ack;
            tick();
            if (got) begin
                acks++;
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("dma_ack_timeout", 32'd0, 32'd1);
        if (l) dma_req = 1'b0;
    endtask

    // Issue one fetch and land one cycle later (outputs now valid).
    task automatic fetch(input logic [31:0] p, input logic fl);
        pc       = p;
        fetch_en = 1'b1;
        flush    = fl;
        tick();
        fetch_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        acks      = 0;
        rst       = 1'b1;
        pc        = BASE;
        fetch_en  = 1'b0;
        flush     = 1'b0;
        dma_req   = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        dma_last  = 1'b0;
        tick();
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc_out, BASE);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ack", 32'(dma_ack), 32'd0);
        chk("rst_stall", 32'(dma_stall), 32'd0);
        rst = 1'b0;
        tick();

        // Preload; one beat is out of range and must be dropped.
        dma_beat(32'h1000_0000, 32'h0050_0093, 1'b0);
        chk("load_stall", 32'(dma_stall), 32'd1);
        dma_beat(32'h1000_0004, 32'h0010_0113, 1'b0);
        dma_beat(32'h1000_1000, 32'hBADB_AD00, 1'b0);
        dma_beat(32'h1000_0008, 32'h0020_81B3, 1'b1);
        chk("load_acks", 32'(acks), 32'd4);
        chk("drain_stall", 32'(dma_stall), 32'd1);
        chk("drain_ack", 32'(dma_ack), 32'd0);
        tick();
        chk("idle_stall", 32'(dma_stall), 32'd0);

        fetch(32'h1000_0000, 1'b0);
        chk("f0_instr", instr, 32'h0050_0093);
        chk("f0_pc", pc_out, 32'h1000_0000);
        chk("f0_valid", 32'(valid), 32'd1);
        chk("f0_err", 32'(err), 32'd0);

        pc = 32'h1000_0008;
        tick();
        chk("hold_instr", instr, 32'h0050_0093);
        chk("hold_pc", pc_out, 32'h1000_0000);
        chk("hold_valid", 32'(valid), 32'd1);

        // Back-to-back stream.
        fetch_en = 1'b1;
        pc       = 32'h1000_0000;
        tick();
        chk("b2b0_instr", instr, 32'h0050_0093);
        pc = 32'h1000_0004;
        tick();
        chk("b2b1_instr", instr, 32'h0010_0113);
        chk("b2b1_pc", pc_out, 32'h1000_0004);
        pc = 32'h1000_0008;
        tick();
        chk("b2b2_instr", instr, 32'h0020_81B3);
        chk("b2b2_pc", pc_out, 32'h1000_0008);
        fetch_en = 1'b0;

        fetch(32'h1000_0004, 1'b1);
        chk("flush_valid", 32'(valid), 32'd0);
        chk("flush_instr", instr, NOP);

        fetch(32'h1000_0002, 1'b0);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_instr", instr, NOP);
        chk("mis_valid", 32'(valid), 32'd1);
        fetch(32'h1000_1000, 1'b0);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_instr", instr, NOP);
        fetch(32'h0FFF_FFFC, 1'b0);
        chk("below_err", 32'(err), 32'd1);
        fetch(32'h1000_0FFC, 1'b0);
        chk("top_err", 32'(err), 32'd0);
        fetch(32'h1000_0000, 1'b0);
        chk("drop_instr", instr, 32'h0050_0093);
        chk("drop_err", 32'(err), 32'd0);

        // Reload, then read-after-write right after DRAIN.
        acks = 0;
        dma_beat(32'h1000_0000, 32'h1111_1111, 1'b0);
        chk("rl_stall", 32'(dma_stall), 32'd1);
        dma_beat(32'h1000_0004, 32'h2222_2222, 1'b0);
        dma_beat(32'h1000_0008, 32'h3333_3333, 1'b1);
        chk("rl_acks", 32'(acks), 32'd3);
        chk("rl_drain", 32'(dma_stall), 32'd1);
        chk("rl_hold_instr", instr, 32'h0050_0093);
        tick();
        fetch(32'h1000_0008, 1'b0);
        chk("raw_instr", instr, 32'h3333_3333);
        chk("raw_pc", pc_out, 32'h1000_0008);

        // Reset mid-load after beat 1.
        dma_beat(32'h1000_0004, 32'hAAAA_5555, 1'b0);
        dma_addr  = 32'h1000_0008;
        dma_wdata = 32'h5A5A_5A5A;
        #1;
        chk("mid_ack", 32'(dma_ack), 32'd1);
        chk("mid_stall", 32'(dma_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_stall", 32'(dma_stall), 32'd0);
        chk("arst_ack", 32'(dma_ack), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        dma_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        fetch(32'h1000_0004, 1'b0);
        chk("keep_beat1", instr, 32'hAAAA_5555);
        fetch(32'h1000_0008, 1'b0);
        chk("no_beat2", instr, 32'h3333_3333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
